// File: rtl/u712_chip_cycle_sm_if.sv
// U712 CPU-to-chipset cycle bus: transfer request, slot/DMA status,
// access strobes and acknowledges.
interface u712_chip_cycle_sm_if;
    logic TS;
    logic RnW;
    logic REG_SEL;
    logic RAM_SEL;
    logic SLOT_OK;
    logic CASUn;
    logic CASLn;
    logic REG_CYCLE;
    logic CPU_CYCLE;
    logic RnW_OUT;
    logic DATA_LATCH;
    logic TACK;
    logic TEA;
    logic BUSY;

    modport master (
        output TS, RnW, REG_SEL, RAM_SEL, SLOT_OK, CASUn, CASLn,
        input  REG_CYCLE, CPU_CYCLE, RnW_OUT, DATA_LATCH, TACK, TEA, BUSY
    );

    modport slave (
        input  TS, RnW, REG_SEL, RAM_SEL, SLOT_OK, CASUn, CASLn,
        output REG_CYCLE, CPU_CYCLE, RnW_OUT, DATA_LATCH, TACK, TEA, BUSY
    );
endinterface

// File: rtl/u712_chip_cycle_sm.sv
// U712 chipset cycle sequencer: IDLE -> WAIT_SLOT -> ACTIVE -> ACK.
// Optional WAIT_SLOT bus-error timeout under U712_CYCLE_TIMEOUT_EN.
module u712_chip_cycle_sm #(
    parameter int ACTIVE_CLKS  = 4,
    parameter int TIMEOUT_CLKS = 255
) (
    input  logic                 CLK40,
    input  logic                 RESET,
    u712_chip_cycle_sm_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT_SLOT, ACTIVE, ACK} state_t;

    localparam logic [3:0] ACT_LAST = 4'(ACTIVE_CLKS - 1);

    if (ACTIVE_CLKS < 2 || ACTIVE_CLKS > 15) begin : g_bad_active
        $error("ACTIVE_CLKS out of range 2..15");
    end
    if (TIMEOUT_CLKS < 16 || TIMEOUT_CLKS > 255) begin : g_bad_timeout
        $error("TIMEOUT_CLKS out of range 16..255");
    end

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       tgt_reg;
    logic       rnw_q;
    logic       accept;
    logic       slot_free;
    logic       timeout;

    logic reg_n, cpu_n, dl_n, tack_n, tea_n, busy_n;
    logic reg_q, cpu_q, dl_q, tack_q, tea_q, busy_q;

    assign accept    = bus.TS && (bus.REG_SEL || bus.RAM_SEL);
    assign slot_free = bus.SLOT_OK && bus.CASUn && bus.CASLn;

`ifdef U712_CYCLE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CLKS - 1);
    logic [7:0] wcnt;

    // Idles at zero so the count is already cleared on WAIT_SLOT entry
    always_ff @(posedge CLK40) begin
        if (RESET)
            wcnt <= 8'd0;
        else if (state == WAIT_SLOT)
            wcnt <= wcnt + 8'd1;
        else
            wcnt <= 8'd0;
    end

    assign timeout = (state == WAIT_SLOT) && !slot_free && (wcnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_n = WAIT_SLOT;
            end
            WAIT_SLOT: begin
                if (slot_free) begin
                    state_n = ACTIVE;
                    cnt_n   = ACT_LAST;
                end else if (timeout) begin
                    state_n = IDLE;
                end
            end
            ACTIVE: begin
                if (cnt == 4'd0)
                    state_n = ACK;
                else
                    cnt_n = cnt - 4'd1;
            end
            ACK: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and then registered
    always_comb begin
        logic in_cycle;
        in_cycle = (state_n == ACTIVE) || (state_n == ACK);
        reg_n    = in_cycle && tgt_reg;
        cpu_n    = in_cycle && !tgt_reg;
        dl_n     = (state_n == ACTIVE) && (cnt_n == 4'd0) && rnw_q;
        tack_n   = (state_n == ACK);
        tea_n    = timeout;
        busy_n   = (state_n != IDLE);
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            tgt_reg <= 1'b0;
            rnw_q   <= 1'b1;
            reg_q   <= 1'b0;
            cpu_q   <= 1'b0;
            dl_q    <= 1'b0;
            tack_q  <= 1'b0;
            tea_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                tgt_reg <= bus.REG_SEL;
                rnw_q   <= bus.RnW;
            end
            reg_q  <= reg_n;
            cpu_q  <= cpu_n;
            dl_q   <= dl_n;
            tack_q <= tack_n;
            tea_q  <= tea_n;
            busy_q <= busy_n;
        end
    end

    assign bus.REG_CYCLE  = reg_q;
    assign bus.CPU_CYCLE  = cpu_q;
    assign bus.RnW_OUT    = rnw_q;
    assign bus.DATA_LATCH = dl_q;
    assign bus.TACK       = tack_q;
    assign bus.TEA        = tea_q;
    assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_u712_chip_cycle_sm.sv
// Directed bench for u712_chip_cycle_sm: edge-by-edge checks of
// strobes, acknowledges, reset abort, back-to-back and slot waiting.
module tb_u712_chip_cycle_sm;

    logic CLK40 = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK40 = ~CLK40;

    u712_chip_cycle_sm_if bus ();

    u712_chip_cycle_sm #(
        .ACTIVE_CLKS  (4),
        .TIMEOUT_CLKS (16)
    ) dut (
        .CLK40 (CLK40),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k,
                           input logic r, input logic c, input logic d,
                           input logic t, input logic e, input logic b);
        chk($sformatf("%s[%0d].REG_CYCLE", tag, k), bus.REG_CYCLE, r);
        chk($sformatf("%s[%0d].CPU_CYCLE", tag, k), bus.CPU_CYCLE, c);
        chk($sformatf("%s[%0d].DATA_LATCH", tag, k), bus.DATA_LATCH, d);
        chk($sformatf("%s[%0d].TACK", tag, k), bus.TACK, t);
        chk($sformatf("%s[%0d].TEA", tag, k), bus.TEA, e);
        chk($sformatf("%s[%0d].BUSY", tag, k), bus.BUSY, b);
    endtask

    task automatic start(input logic rs, input logic ms, input logic rnw);
        bus.TS      = 1'b1;
        bus.REG_SEL = rs;
        bus.RAM_SEL = ms;
        bus.RnW     = rnw;
        tick();
        bus.TS      = 1'b0;
        bus.REG_SEL = 1'b0;
        bus.RAM_SEL = 1'b0;
        bus.RnW     = ~rnw;
    endtask

    // Slot free at the first WAIT_SLOT edge: strobe after edges 1..5,
    // DATA_LATCH after edge 4 on reads, TACK after edge 5, idle after 6
    task automatic run_free(input string tag, input logic rs,
                            input logic ms, input logic rnw);
        logic is_reg;
        logic act;
        is_reg = rs;
        start(rs, ms, rnw);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            act = (k >= 1) && (k <= 5);
            chk_all(tag, k, act && is_reg, act && !is_reg,
                    (k == 4) && rnw, k == 5, 1'b0, k <= 5);
            if (k == 3)
                chk({tag, ".RnW_OUT"}, bus.RnW_OUT, rnw);
        end
    endtask

    // RAM read whose slot opens at edge s: strobe s..s+4, TACK at s+4
    task automatic run_slot_at(input string tag, input int s);
        logic act;
        bus.SLOT_OK = 1'b0;
        start(1'b0, 1'b1, 1'b1);
        for (int k = 0; k <= s + 5; k++) begin
            if (k > 0) begin
                if (k == s) bus.SLOT_OK = 1'b1;
                tick();
            end
            act = (k >= s) && (k <= s + 4);
            chk_all(tag, k, 1'b0, act, k == s + 3, k == s + 4,
                    1'b0, k <= s + 4);
        end
    endtask

    initial begin
        logic act;
        RESET       = 1'b1;
        bus.TS      = 1'b0;
        bus.RnW     = 1'b0;
        bus.REG_SEL = 1'b0;
        bus.RAM_SEL = 1'b0;
        bus.SLOT_OK = 1'b1;
        bus.CASUn   = 1'b1;
        bus.CASLn   = 1'b1;
        tick();
        tick();
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.RnW_OUT", bus.RnW_OUT, 1'b1);
        RESET = 1'b0;

        run_free("rd_reg", 1'b1, 1'b0, 1'b1);

        // RAM write held off by CASLn low for edges 0..9
        bus.CASLn = 1'b0;
        start(1'b0, 1'b1, 1'b0);
        for (int k = 0; k <= 15; k++) begin
            if (k > 0) begin
                if (k == 10) bus.CASLn = 1'b1;
                tick();
            end
            act = (k >= 10) && (k <= 14);
            chk_all("wr_dma", k, 1'b0, act, 1'b0, k == 14, 1'b0, k <= 14);
            if (k == 12)
                chk("wr_dma.RnW_OUT", bus.RnW_OUT, 1'b0);
        end
        chk("wr_dma.RnW_OUT_idle", bus.RnW_OUT, 1'b0);

        run_free("both_sel", 1'b1, 1'b1, 1'b1);

        start(1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick();
            chk_all("no_sel", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset during the second clock of a register write
        start(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_mid.pre_REG_CYCLE", bus.REG_CYCLE, 1'b1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_all("rst_mid", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid.RnW_OUT", bus.RnW_OUT, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_all("rst_quiet", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        run_free("after_rst", 1'b0, 1'b1, 1'b0);

        run_free("b2b_a", 1'b1, 1'b0, 1'b1);
        run_free("b2b_b", 1'b0, 1'b1, 1'b0);

`ifdef U712_CYCLE_TIMEOUT_EN
        // TIMEOUT_CLKS=16: final count sampled at edge 16
        bus.SLOT_OK = 1'b0;
        start(1'b0, 1'b1, 1'b1);
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) tick();
            chk_all("timeout", k, 1'b0, 1'b0, 1'b0, 1'b0, k == 16, k < 16);
        end
        run_slot_at("slot_at_last", 16);
`else
        run_slot_at("long_wait", 21);
`endif

        bus.SLOT_OK = 1'b1;
        run_free("final", 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/u712_chip_cycle_sm.md
# u712_chip_cycle_sm

CPU-to-chipset cycle sequencer for U712. It accepts a decoded CPU transfer targeting chip registers or chip RAM and waits for a free chipset slot outside Agnus DMA. It then runs a fixed-length access and returns a transfer acknowledge to the CPU bus logic. Its REG_CYCLE, CPU_CYCLE and RnW_OUT outputs feed the chipset data buffer enable/direction logic directly downstream.

## Interface
Parameters:
- ACTIVE_CLKS, 4: clocks the access strobe (REG_CYCLE/CPU_CYCLE) stays asserted; legal range 2..15.
- TIMEOUT_CLKS, 255: maximum clocks spent in WAIT_SLOT before bus error; legal range 16..255. Used only with the timeout feature.

Ports:
- CLK40 input 1: system clock; all state changes on the rising edge.
- RESET input 1: synchronous, active-high reset.
- TS input 1: transfer start, one-clock high pulse from CPU bus logic.
- RnW input 1: CPU direction, sampled with TS; 1 = read.
- REG_SEL input 1: address decode hit on chip registers, sampled with TS.
- RAM_SEL input 1: address decode hit on chip RAM, sampled with TS.
- SLOT_OK input 1: high when the chipset timing permits a CPU access to start.
- CASUn, CASLn input 1 each: Agnus CAS strobes, active low; either low means a DMA cycle is active.
- REG_CYCLE output 1: chip register access in progress.
- CPU_CYCLE output 1: chip RAM access in progress.
- RnW_OUT output 1: registered direction of the current access.
- DATA_LATCH output 1: one-clock pulse that captures read data.
- TACK output 1: one-clock transfer acknowledge pulse.
- TEA output 1: one-clock transfer error pulse.
- BUSY output 1: high in any state other than IDLE.

## Operation
- States: IDLE, WAIT_SLOT, ACTIVE, ACK.
- IDLE: on TS=1 with REG_SEL or RAM_SEL high, latch target and RnW and go to WAIT_SLOT.
  - If both selects are high, the target is register.
  - If TS=1 with neither select high, the request is ignored: stay IDLE, no TACK.
- WAIT_SLOT: when SLOT_OK=1, CASUn=1 and CASLn=1 in the same clock, go to ACTIVE. Otherwise stay.
- ACTIVE:
  - Assert REG_CYCLE or CPU_CYCLE according to the latched target. Never assert both.
  - A 4-bit down counter loads ACTIVE_CLKS-1 on entry and decrements each clock.
  - At count 0, go to ACK. If the access is a read, pulse DATA_LATCH on that count-0 clock.
  - CAS going low during ACTIVE does not abort the access. Slot arbitration is upstream of this block.
- ACK: TACK=1 for exactly one clock. The cycle output stays asserted during ACK, then the block returns to IDLE.
- TS while BUSY: ignored. The CPU bus never issues overlapping transfers, and no queuing is required.
- RnW_OUT holds its last value in IDLE. Reset value is 1 (read), which is the safe buffer direction.

## Timing
- Reset: after one RESET edge, state=IDLE, REG_CYCLE=0, CPU_CYCLE=0, RnW_OUT=1, DATA_LATCH=0, TACK=0, TEA=0, BUSY=0, counters=0.
- RESET asserted mid-cycle forces IDLE on the next edge with all strobes low and no TACK or TEA. The aborted transfer is not acknowledged.
- Edge sequence, relative to the TS edge:
  - Edge 0: TS sampled.
  - Edge 1: BUSY=1. State is WAIT_SLOT.
  - Slot condition true at edge N: cycle output asserts after edge N.
  - Cycle output is high for ACTIVE_CLKS+1 clocks: ACTIVE_CLKS in ACTIVE plus one in ACK.
  - TACK is high in the last of those clocks.
  - Everything is low the clock after TACK.
- Minimum latency with the slot free immediately: TS edge to TACK = ACTIVE_CLKS+2 clocks (6 at default).
- A new TS is accepted on the clock following TACK (back-to-back transfers).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- U712_CYCLE_TIMEOUT_EN defined:
  - An 8-bit counter clears on WAIT_SLOT entry and increments each clock in WAIT_SLOT.
  - When the count reaches TIMEOUT_CLKS-1 without the slot condition, pulse TEA for one clock, run no cycle, and return to IDLE.
  - If the slot condition and the final count occur in the same clock, the slot wins: go to ACTIVE with no TEA.
- Not defined: WAIT_SLOT waits indefinitely, the timeout counter is absent, and TEA is tied to 0.

## Test plan
- Register read, SLOT_OK=1, CAS high: TS+REG_SEL+RnW=1.
  - Expect REG_CYCLE high for 5 clocks, DATA_LATCH on clock 4 of the access, TACK 6 clocks after TS, CPU_CYCLE=0 throughout.
- RAM write blocked by DMA: CASLn low for 10 clocks after TS with RAM_SEL, RnW=0.
  - Expect CPU_CYCLE to assert only after CASLn rises, no DATA_LATCH, TACK once, RnW_OUT=0.
- Both selects high: TS with REG_SEL=RAM_SEL=1.
  - Expect REG_CYCLE only. Then TS with no select: expect BUSY to stay 0 and no TACK.
- Reset mid-ACTIVE: assert RESET on clock 2 of the access.
  - Expect all outputs at reset values on the next edge, no TACK. A following TS completes normally.
- Timeout with U712_CYCLE_TIMEOUT_EN defined, TIMEOUT_CLKS=16, SLOT_OK=0 held:
  - Expect TEA one clock, 17 clocks after TS, and no cycle output.
  - Repeat with SLOT_OK rising on the final count: expect an access with no TEA.
- Back-to-back: second TS on the clock after TACK.
  - Expect the second access to start with the same latency, and no TS loss.
